// File: rtl/palindrome_3_bit_if.sv
// -----------------------------------------------------------------------------
// palindrome_3_bit_if
// Read-port bundle for the palindrome_3_bit event counter.
//   req_i    : read request from the requester
//   atomic_i : clear-on-read qualifier for an accepted request
//   ack_o    : one-cycle acknowledge from the counter
//   count_o  : 32-bit snapshot, valid while ack_o is high
// Modports:
//   master : requester side (drives req_i/atomic_i)
//   slave  : counter side (drives ack_o/count_o)
// -----------------------------------------------------------------------------
interface palindrome_3_bit_if;
   logic        req_i;
   logic        atomic_i;
   logic        ack_o;
   logic [31:0] count_o;

   modport master (
      output req_i,
      output atomic_i,
      input  ack_o,
      input  count_o
   );

   modport slave (
      input  req_i,
      input  atomic_i,
      output ack_o,
      output count_o
   );
endinterface : palindrome_3_bit_if

// File: rtl/palindrome_3_bit.sv
// -----------------------------------------------------------------------------
// palindrome_3_bit
// 32-bit event counter with a request/acknowledge snapshot read port.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-low reset
//   trig_i : event strobe, one event per high cycle
//   bus    : read port (slave side): req_i, atomic_i in; ack_o, count_o out
// A read captures the counter as it stood before the accepting edge; an
// atomic read restarts the counter from the event (if any) seen in that same
// cycle, so no event is ever dropped.
// -----------------------------------------------------------------------------
module palindrome_3_bit (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  trig_i,
   palindrome_3_bit_if.slave     bus
);

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] snap_q, snap_d;

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + {31'd0, trig_i};
      snap_d  = snap_q;

      case (state_q)
         IDLE: begin
            if (bus.req_i) begin
               snap_d  = cnt_q;
               state_d = ACK;
               // Clearing still keeps an event arriving in the request cycle.
               if (bus.atomic_i) begin
                  cnt_d = {31'd0, trig_i};
               end
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 32'd0;
         snap_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         snap_q  <= snap_d;
      end
   end

   // Outputs straight from flops
   assign bus.ack_o   = (state_q == ACK);
   assign bus.count_o = snap_q;

endmodule : palindrome_3_bit

// File: tb/tb_palindrome_3_bit.sv
// -----------------------------------------------------------------------------
// tb_palindrome_3_bit
// Directed bench for palindrome_3_bit. Inputs change 1 time unit after the
// rising edge; outputs are sampled at that same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_palindrome_3_bit;

   logic clk;
   logic rst;
   logic trig_i;
   int   total;
   int   bad;

   palindrome_3_bit_if bus ();

   palindrome_3_bit dut (
      .clk    (clk),
      .rst    (rst),
      .trig_i (trig_i),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle just past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst          = 1'b0;
      trig_i       = 1'b1;
      bus.req_i    = 1'b1;
      bus.atomic_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++;
         if (bus.ack_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_ack cyc=%0d got=%b want=0", i, bus.ack_o);
         end
         total++;
         if (bus.count_o !== 32'd0) begin
            bad++;
            $display("FAIL reset_count cyc=%0d got=%h want=00000000", i, bus.count_o);
         end
      end
      rst       = 1'b1;
      trig_i    = 1'b0;
      bus.req_i = 1'b0;
      tick();
      total++;
      if (bus.ack_o !== 1'b0 || bus.count_o !== 32'd0) begin
         bad++;
         $display("FAIL reset_release got ack=%b count=%h want ack=0 count=00000000",
                  bus.ack_o, bus.count_o);
      end
   endtask

   task automatic test_count_read();
      trig_i = 1'b1;
      repeat (5) tick();
      trig_i       = 1'b0;
      bus.req_i    = 1'b1;
      bus.atomic_i = 1'b0;
      tick();
      bus.req_i = 1'b0;
      total++;
      if (bus.ack_o !== 1'b1 || bus.count_o !== 32'd5) begin
         bad++;
         $display("FAIL count_read1 got ack=%b count=%0d want ack=1 count=5",
                  bus.ack_o, bus.count_o);
      end
      tick();
      total++;
      if (bus.ack_o !== 1'b0) begin
         bad++;
         $display("FAIL ack_one_cycle got=%b want=0", bus.ack_o);
      end
      bus.req_i = 1'b1;
      tick();
      bus.req_i = 1'b0;
      total++;
      if (bus.ack_o !== 1'b1 || bus.count_o !== 32'd5) begin
         bad++;
         $display("FAIL count_read2 got ack=%b count=%0d want ack=1 count=5",
                  bus.ack_o, bus.count_o);
      end
      tick();
   endtask

   task automatic test_atomic_clear();
      // Clear the leftover 5 first.
      bus.req_i    = 1'b1;
      bus.atomic_i = 1'b1;
      tick();
      bus.req_i    = 1'b0;
      bus.atomic_i = 1'b0;
      tick();
      trig_i = 1'b1;
      repeat (7) tick();
      bus.req_i    = 1'b1;
      bus.atomic_i = 1'b1;
      trig_i       = 1'b1;
      tick();
      bus.req_i    = 1'b0;
      bus.atomic_i = 1'b0;
      trig_i       = 1'b0;
      total++;
      if (bus.ack_o !== 1'b1 || bus.count_o !== 32'd7) begin
         bad++;
         $display("FAIL atomic_snap got ack=%b count=%0d want ack=1 count=7",
                  bus.ack_o, bus.count_o);
      end
      tick();
      bus.req_i = 1'b1;
      tick();
      bus.req_i = 1'b0;
      total++;
      if (bus.ack_o !== 1'b1 || bus.count_o !== 32'd1) begin
         bad++;
         $display("FAIL atomic_keep_event got ack=%b count=%0d want ack=1 count=1",
                  bus.ack_o, bus.count_o);
      end
      tick();
   endtask

   task automatic test_held_request();
      logic        exp_ack [6];
      logic [31:0] exp_cnt [6];
      // Counter holds 1: clear it without an event, then idle one cycle.
      bus.req_i    = 1'b1;
      bus.atomic_i = 1'b1;
      tick();
      bus.req_i    = 1'b0;
      bus.atomic_i = 1'b0;
      tick();
      exp_ack = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      exp_cnt = '{32'd0, 32'd0, 32'd0, 32'd2, 32'd0, 32'd4};
      bus.req_i = 1'b1;
      trig_i    = 1'b1;
      for (int k = 0; k < 6; k++) begin
         total++;
         if (bus.ack_o !== exp_ack[k]) begin
            bad++;
            $display("FAIL held_ack cyc=%0d got=%b want=%b", k, bus.ack_o, exp_ack[k]);
         end
         if (exp_ack[k]) begin
            total++;
            if (bus.count_o !== exp_cnt[k]) begin
               bad++;
               $display("FAIL held_count cyc=%0d got=%0d want=%0d", k, bus.count_o, exp_cnt[k]);
            end
         end
         tick();
      end
      bus.req_i = 1'b0;
      trig_i    = 1'b0;
      tick();
   endtask

   task automatic test_wrap();
      @(negedge clk);
      force dut.cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.cnt_q;
      tick();
      trig_i = 1'b1;
      repeat (3) tick();
      trig_i    = 1'b0;
      bus.req_i = 1'b1;
      tick();
      bus.req_i = 1'b0;
      total++;
      if (bus.ack_o !== 1'b1 || bus.count_o !== 32'h0000_0001) begin
         bad++;
         $display("FAIL wrap got ack=%b count=%h want ack=1 count=00000001",
                  bus.ack_o, bus.count_o);
      end
      tick();
   endtask

   task automatic test_reset_in_ack();
      bus.req_i = 1'b1;
      tick();
      total++;
      if (bus.ack_o !== 1'b1) begin
         bad++;
         $display("FAIL rack_accept got=%b want=1", bus.ack_o);
      end
      bus.req_i = 1'b0;
      rst       = 1'b0;
      trig_i    = 1'b1;
      tick();
      total++;
      if (bus.ack_o !== 1'b0 || bus.count_o !== 32'd0) begin
         bad++;
         $display("FAIL rack_abort got ack=%b count=%h want ack=0 count=00000000",
                  bus.ack_o, bus.count_o);
      end
      rst    = 1'b1;
      trig_i = 1'b1;
      tick();
      trig_i    = 1'b0;
      bus.req_i = 1'b1;
      tick();
      bus.req_i = 1'b0;
      total++;
      if (bus.ack_o !== 1'b1 || bus.count_o !== 32'd1) begin
         bad++;
         $display("FAIL rack_restart got ack=%b count=%0d want ack=1 count=1",
                  bus.ack_o, bus.count_o);
      end
      tick();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_count_read();
      test_atomic_clear();
      test_held_request();
      test_wrap();
      test_reset_in_ack();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_palindrome_3_bit

// File: doc/palindrome_3_bit.md
# palindrome_3_bit

Event counter with a request/acknowledge read port. Single-cycle `trig_i` events accumulate in a 32-bit counter. A requester reads the count through `req_i`/`ack_o` and may optionally clear it atomically in the same cycle. The block sits between event sources and a register/APB-style read path, providing a lossless snapshot of the event count.

## Interface
- No parameters. Counter width is fixed at 32 bits.
- `clk` in 1: the single clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-low. The block resets on any rising `clk` edge that samples `rst==0`.
- `trig_i` in 1: event strobe; each cycle it is high counts as one event.
- `req_i` in 1: read request, sampled only in IDLE.
- `atomic_i` in 1: qualifies `req_i`; when high with an accepted request, the counter is cleared as part of the read.
- `ack_o` out 1: one-cycle acknowledge; `count_o` is valid while it is high.
- `count_o` out 32: snapshot of the counter captured at the accepted request.

## Operation
- Internal state:
  - `cnt[31:0]`: live counter.
  - `snap[31:0]`: drives `count_o`.
  - FSM with states IDLE and ACK.
- Counting:
  - Every cycle with `trig_i==1` adds 1 to `cnt`, modulo 2^32.
  - At 0xFFFF_FFFF, the next increment wraps to 0. No overflow flag.
- IDLE with `req_i==1` (request accepted):
  - `snap` <= `cnt` as it was before this edge. A `trig_i` in the request cycle is not included.
  - If `atomic_i==1`: `cnt` <= `trig_i` ? 1 : 0. A simultaneous event is never lost.
  - If `atomic_i==0`: `cnt` <= `cnt + trig_i`.
  - Next state is ACK.
- IDLE with `req_i==0`: stay in IDLE. `atomic_i` is ignored.
- ACK:
  - `ack_o` is 1.
  - Next state is unconditionally IDLE.
  - `req_i` and `atomic_i` are ignored in ACK. A held `req_i` is re-accepted in the following IDLE cycle.
- `count_o` is always `snap`. It holds its value between acknowledges and changes only on request acceptance.
- Reset (`rst==0` at an edge): `cnt`=0, `snap`=0, state=IDLE.
  - Reset has priority over `trig_i` and `req_i` in the same cycle.
  - Reset during ACK aborts the acknowledge: `ack_o` is 0 the next cycle.

## Timing
- Reset values: `ack_o`=0, `count_o`=0x0000_0000.
- Latency:
  - Request accepted at edge N: `ack_o`=1 and `count_o` valid during cycle N+1 (registered).
  - `ack_o` is high for exactly one cycle.
- Maximum request throughput is one accepted request per 2 cycles. With `req_i` held high, `ack_o` toggles 0,1,0,1,…
- Counter update latency is 1 cycle. An event at edge N is visible in a snapshot taken at edge N+1 or later.
- No combinational path from any input to any output. All outputs come directly from flops.

## Test plan
- Reset: hold `rst`=0 for 2 cycles while driving `trig_i`=1 and `req_i`=1. Required: `ack_o`=0, `count_o`=0 throughout and after release.
- Count and read: 5 `trig_i` pulses, then `req_i`=1, `atomic_i`=0 for one cycle. Required: next cycle `ack_o`=1, `count_o`=5. A second read with no new events also returns 5.
- Atomic clear with simultaneous event: count 7, then `req_i`=1, `atomic_i`=1, `trig_i`=1 in the same cycle. Required: `count_o`=7. A following non-atomic read returns 1.
- Held request: `req_i`=1 held 6 cycles with `trig_i`=1 every cycle from a cleared counter. Required: `ack_o` pattern 0,1,0,1,0,1. `count_o` values 0, 2, 4, captured at the accept edges.
- Wrap: preload `cnt` to 0xFFFF_FFFE (via 0xFFFF_FFFE events or a force), then 3 events and a read. Required: `count_o`=0x0000_0001.
- Reset during ACK: accept a request, assert `rst`=0 in the ACK cycle. Required: `ack_o`=0 and `count_o`=0 the following cycle, and the counter restarts from 0.
